// File: rtl/rr_log_pkg.sv
// Shared types for the record/replay log arbiter and its round-robin picker.
// Combinational helpers only; no state lives here.
package rr_log_pkg;

   localparam int RR_LOG_ARB_MAX_SRC = 8;

   typedef enum logic {
      ARB  = 1'b0,
      HOLD = 1'b1
   } arb_state_e;

   typedef logic [$clog2(RR_LOG_ARB_MAX_SRC)-1:0] src_id_t;

   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_log_arbiter_if.sv
// Source-side and output-side beat streams of the log arbiter.
// slave = arbiter view, master = view of whoever drives sources and sinks output.
interface rr_log_arbiter_if #(
   parameter int NUM_SRC    = 2,
   parameter int DATA_WIDTH = 512
);
   localparam int ID_WIDTH = rr_log_pkg::id_width(NUM_SRC);

   logic [NUM_SRC-1:0]            src_valid;
   logic [NUM_SRC-1:0]            src_last;
   logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
   logic [NUM_SRC-1:0]            src_ready;
   logic                          out_valid;
   logic                          out_last;
   logic [DATA_WIDTH-1:0]         out_data;
   logic [ID_WIDTH-1:0]           out_src_id;
   logic                          out_ready;

   modport slave (
      input  src_valid, src_last, src_data, out_ready,
      output src_ready, out_valid, out_last, out_data, out_src_id
   );

   modport master (
      output src_valid, src_last, src_data, out_ready,
      input  src_ready, out_valid, out_last, out_data, out_src_id
   );

endinterface

// File: rtl/rr_rr_picker.sv
// Round-robin priority picker: first set req scanning ptr+1, ptr+2, ... mod NUM_SRC.
// Purely combinational.
module rr_rr_picker #(
   parameter  int NUM_SRC  = 2,
   localparam int ID_WIDTH = rr_log_pkg::id_width(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0]  req,
   input  logic [ID_WIDTH-1:0] ptr,
   output logic                any,
   output logic [ID_WIDTH-1:0] idx
);

   logic [31:0] pos;

   // Scan farthest offset first so the nearest requester after ptr wins.
   always_comb begin
      any = 1'b0;
      idx = '0;
      pos = '0;
      for (int k = NUM_SRC; k >= 1; k--) begin
         pos = 32'(ptr) + 32'(k);
         if (pos >= 32'(NUM_SRC)) pos = pos - 32'(NUM_SRC);
         if (req[pos[ID_WIDTH-1:0]]) begin
            any = 1'b1;
            idx = pos[ID_WIDTH-1:0];
         end
      end
   end

endmodule

// File: rtl/rr_log_arbiter.sv
// Round-robin arbiter merging multi-beat log records into one stream, grant held to last beat.
// One registered output stage (1-cycle latency, 1 beat/cycle); record_en stops at record boundaries.
module rr_log_arbiter
   import rr_log_pkg::*;
#(
   parameter int NUM_SRC    = 2,
   parameter int DATA_WIDTH = 512,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         record_en,
   rr_log_arbiter_if.slave              bus,
   output logic                         drained,
   output logic [NUM_SRC*CNT_WIDTH-1:0] rec_cnt
);

   localparam int ID_WIDTH = id_width(NUM_SRC);

   arb_state_e          state, state_nxt;
   logic [ID_WIDTH-1:0] rr_ptr, cur_src, pick_idx, sel;
   logic                pick_any, slot_free, grant_now, ready_en, beat_acc, beat_last;

   rr_rr_picker #(.NUM_SRC(NUM_SRC)) u_picker (
      .req (bus.src_valid),
      .ptr (rr_ptr),
      .any (pick_any),
      .idx (pick_idx)
   );

   assign slot_free = !bus.out_valid | bus.out_ready;
   assign grant_now = (state == ARB) & record_en & pick_any & slot_free;
   assign sel       = (state == HOLD) ? cur_src : pick_idx;
   assign ready_en  = !rst & slot_free & ((state == HOLD) | grant_now);
   assign beat_acc  = ready_en & bus.src_valid[sel];
   assign beat_last = bus.src_last[sel];
   assign drained   = !record_en & (state == ARB) & !bus.out_valid;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      logic [CNT_WIDTH-1:0] cnt;

      assign bus.src_ready[i] = ready_en & (sel == ID_WIDTH'(i));
      assign rec_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt <= '0;
         end else if (beat_acc && beat_last && sel == ID_WIDTH'(i) && cnt != '1) begin
            cnt <= cnt + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ARB;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ARB:     if (grant_now && !beat_last) state_nxt = HOLD;
         HOLD:    if (beat_acc && beat_last)   state_nxt = ARB;
         default: state_nxt = ARB;
      endcase
   end

   // Reset pointer to the last source so source 0 wins the first scan.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr  <= ID_WIDTH'(NUM_SRC - 1);
         cur_src <= '0;
      end else if (grant_now) begin
         rr_ptr  <= pick_idx;
         cur_src <= pick_idx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_valid  <= 1'b0;
         bus.out_last   <= 1'b0;
         bus.out_data   <= '0;
         bus.out_src_id <= '0;
      end else if (beat_acc) begin
         bus.out_valid  <= 1'b1;
         bus.out_last   <= beat_last;
         bus.out_data   <= bus.src_data[sel*DATA_WIDTH +: DATA_WIDTH];
         bus.out_src_id <= sel;
      end else if (bus.out_ready) begin
         bus.out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rr_log_arbiter.sv
// Directed bench for rr_log_arbiter: NUM_SRC=2, 32-bit payload, 4-bit counters.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_rr_log_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       rec_en;
   logic       drained;
   logic [7:0] rec_cnt;
   int         total = 0;
   int         bad   = 0;

   always #5 clk = ~clk;

   rr_log_arbiter_if #(.NUM_SRC(2), .DATA_WIDTH(32)) bus ();

   rr_log_arbiter #(.NUM_SRC(2), .DATA_WIDTH(32), .CNT_WIDTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .record_en (rec_en),
      .bus       (bus.slave),
      .drained   (drained),
      .rec_cnt   (rec_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic l,
                          input logic [31:0] d, input logic id);
      chk({tag, ".valid"}, 64'(bus.out_valid), 64'(v));
      chk({tag, ".last"},  64'(bus.out_last),  64'(l));
      chk({tag, ".data"},  64'(bus.out_data),  64'(d));
      chk({tag, ".id"},    64'(bus.out_src_id), 64'(id));
   endtask

   task automatic chk_rdy(input string tag, input logic [1:0] exp);
      chk({tag, ".ready"}, 64'(bus.src_ready), 64'(exp));
   endtask

   initial begin
      rst = 1'b1;
      rec_en = 1'b0;
      bus.src_valid = 2'b00;
      bus.src_last  = 2'b00;
      bus.src_data  = '0;
      bus.out_ready = 1'b0;
      #2;
      chk_out("reset", 1'b0, 1'b0, 32'h0, 1'b0);
      chk_rdy("reset", 2'b00);
      chk("reset.cnt", 64'(rec_cnt), 64'h00);
      chk("reset.drained", 64'(drained), 64'h1);
      tick();
      tick();
      rst = 1'b0;

      // Alternating single-beat records
      rec_en = 1'b1;
      bus.src_valid = 2'b11;
      bus.src_last  = 2'b11;
      bus.src_data  = {32'hB000_0000, 32'hA000_0000};
      bus.out_ready = 1'b1;
      settle();
      chk_rdy("alt0", 2'b01);
      chk("alt0.drained", 64'(drained), 64'h0);
      tick();
      bus.src_data = {32'hB000_0000, 32'hA000_0001};
      settle();
      chk_out("alt1", 1'b1, 1'b1, 32'hA000_0000, 1'b0);
      chk_rdy("alt1", 2'b10);
      tick();
      bus.src_data = {32'hB000_0001, 32'hA000_0001};
      settle();
      chk_out("alt2", 1'b1, 1'b1, 32'hB000_0000, 1'b1);
      chk_rdy("alt2", 2'b01);
      tick();
      settle();
      chk_out("alt3", 1'b1, 1'b1, 32'hA000_0001, 1'b0);
      chk_rdy("alt3", 2'b10);
      tick();
      bus.src_valid = 2'b00;
      settle();
      chk_out("alt4", 1'b1, 1'b1, 32'hB000_0001, 1'b1);
      chk("alt4.cnt", 64'(rec_cnt), 64'h22);
      chk_rdy("alt4", 2'b00);
      tick();
      settle();
      chk("alt5.valid", 64'(bus.out_valid), 64'h0);

      // 3-beat src0 record; src1 waits through HOLD
      bus.src_valid = 2'b01;
      bus.src_last  = 2'b00;
      bus.src_data  = {32'hD000_0000, 32'hC000_0000};
      settle();
      chk_rdy("hold0", 2'b01);
      tick();
      bus.src_data  = {32'hD000_0000, 32'hC000_0001};
      bus.src_valid = 2'b11;
      bus.src_last  = 2'b10;
      settle();
      chk_out("hold1", 1'b1, 1'b0, 32'hC000_0000, 1'b0);
      chk_rdy("hold1", 2'b01);
      tick();
      bus.src_data = {32'hD000_0000, 32'hC000_0002};
      bus.src_last = 2'b11;
      settle();
      chk_out("hold2", 1'b1, 1'b0, 32'hC000_0001, 1'b0);
      chk_rdy("hold2", 2'b01);
      tick();
      bus.src_valid = 2'b10;
      settle();
      chk_out("hold3", 1'b1, 1'b1, 32'hC000_0002, 1'b0);
      chk_rdy("hold3", 2'b10);
      tick();
      bus.src_valid = 2'b00;
      settle();
      chk_out("hold4", 1'b1, 1'b1, 32'hD000_0000, 1'b1);
      chk("hold4.cnt", 64'(rec_cnt), 64'h33);

      // Output stall for 5 cycles mid-record
      tick();
      bus.src_valid = 2'b01;
      bus.src_last  = 2'b00;
      bus.src_data  = {32'h0, 32'hE000_0000};
      settle();
      chk("stall0.valid", 64'(bus.out_valid), 64'h0);
      chk_rdy("stall0", 2'b01);
      tick();
      bus.src_data  = {32'h0, 32'hE000_0001};
      bus.out_ready = 1'b0;
      settle();
      chk_out("stall1", 1'b1, 1'b0, 32'hE000_0000, 1'b0);
      chk_rdy("stall1", 2'b00);
      for (int s = 0; s < 5; s++) begin
         tick();
         chk("stall.valid", 64'(bus.out_valid), 64'h1);
         chk("stall.data", 64'(bus.out_data), 64'hE000_0000);
         chk_rdy("stall", 2'b00);
      end
      bus.out_ready = 1'b1;
      settle();
      chk_rdy("stall_rel", 2'b01);
      tick();
      bus.src_data = {32'h0, 32'hE000_0002};
      bus.src_last = 2'b01;
      settle();
      chk_out("stall2", 1'b1, 1'b0, 32'hE000_0001, 1'b0);
      tick();
      bus.src_valid = 2'b00;
      settle();
      chk_out("stall3", 1'b1, 1'b1, 32'hE000_0002, 1'b0);
      chk("stall3.cnt", 64'(rec_cnt), 64'h34);

      // record_en dropped during a 4-beat src1 record
      tick();
      bus.src_valid = 2'b11;
      bus.src_last  = 2'b01;
      bus.src_data  = {32'h6000_0000, 32'hF000_0000};
      settle();
      chk("quiesce0.valid", 64'(bus.out_valid), 64'h0);
      chk_rdy("quiesce0", 2'b10);
      tick();
      rec_en = 1'b0;
      bus.src_data = {32'h6000_0001, 32'hF000_0000};
      settle();
      chk_out("quiesce1", 1'b1, 1'b0, 32'h6000_0000, 1'b1);
      chk_rdy("quiesce1", 2'b10);
      chk("quiesce1.drained", 64'(drained), 64'h0);
      tick();
      bus.src_data = {32'h6000_0002, 32'hF000_0000};
      settle();
      chk_out("quiesce2", 1'b1, 1'b0, 32'h6000_0001, 1'b1);
      chk_rdy("quiesce2", 2'b10);
      tick();
      bus.src_data = {32'h6000_0003, 32'hF000_0000};
      bus.src_last = 2'b11;
      settle();
      chk_out("quiesce3", 1'b1, 1'b0, 32'h6000_0002, 1'b1);
      chk_rdy("quiesce3", 2'b10);
      tick();
      bus.src_valid = 2'b01;
      settle();
      chk_out("quiesce4", 1'b1, 1'b1, 32'h6000_0003, 1'b1);
      chk_rdy("quiesce4", 2'b00);
      chk("quiesce4.drained", 64'(drained), 64'h0);
      chk("quiesce4.cnt", 64'(rec_cnt), 64'h44);
      tick();
      settle();
      chk("quiesce5.valid", 64'(bus.out_valid), 64'h0);
      chk("quiesce5.drained", 64'(drained), 64'h1);
      chk_rdy("quiesce5", 2'b00);
      tick();
      settle();
      chk_rdy("quiesce6", 2'b00);
      chk("quiesce6.valid", 64'(bus.out_valid), 64'h0);
      chk("quiesce6.cnt", 64'(rec_cnt), 64'h44);
      rec_en = 1'b1;
      settle();
      chk_rdy("resume0", 2'b01);
      chk("resume0.drained", 64'(drained), 64'h0);
      tick();
      bus.src_valid = 2'b00;
      settle();
      chk_out("resume1", 1'b1, 1'b1, 32'hF000_0000, 1'b0);
      chk("resume1.cnt", 64'(rec_cnt), 64'h45);

      // Async reset in the middle of a HOLD
      tick();
      bus.src_valid = 2'b01;
      bus.src_last  = 2'b00;
      bus.src_data  = {32'h0, 32'h1234_0000};
      settle();
      chk_rdy("arst0", 2'b01);
      tick();
      settle();
      chk_out("arst1", 1'b1, 1'b0, 32'h1234_0000, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk_out("arst2", 1'b0, 1'b0, 32'h0, 1'b0);
      chk_rdy("arst2", 2'b00);
      chk("arst2.cnt", 64'(rec_cnt), 64'h00);
      tick();
      rst = 1'b0;
      bus.src_valid = 2'b11;
      bus.src_last  = 2'b11;
      bus.src_data  = {32'h5000_0000, 32'h4000_0000};
      settle();
      chk_rdy("arst3", 2'b01);
      tick();
      bus.src_valid = 2'b01;
      settle();
      chk_out("arst4", 1'b1, 1'b1, 32'h4000_0000, 1'b0);

      // Counter saturation: 17 single-beat records from src0 in total
      for (int r = 0; r < 14; r++) tick();
      settle();
      chk("sat15.cnt", 64'(rec_cnt), 64'h0F);
      for (int r = 0; r < 2; r++) tick();
      bus.src_valid = 2'b00;
      settle();
      chk("sat17.cnt", 64'(rec_cnt), 64'h0F);
      tick();
      settle();
      chk("sat_end.valid", 64'(bus.out_valid), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
